// File: rtl/imem_boot_loader.sv
// Boot-time instruction loader: assembles a little-endian byte stream into
// 32-bit words, writes them from word address 0, and holds the core in reset until done.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    LOAD,
    WRITE,
    DONE,
    ERR
  } loadState_t;

  // One bit wider than the count so a full 2^16-word memory still compares correctly.
  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

  loadState_t            state;
  loadState_t            nextState;
  logic [7:0]            countLo;
  logic [15:0]           remaining;
  logic [ADDR_WIDTH-1:0] wordAddr;
  logic [1:0]            byteCnt;
  logic [31:0]           wordBuf;
  logic [15:0]           fullCount;
  logic                  xfer;

  assign xfer      = byte_valid && byte_ready;
  assign fullCount = {byte_data, countLo};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE, DONE, ERR: if (start) nextState = LEN_LO;
      LEN_LO:          if (xfer) nextState = LEN_HI;
      LEN_HI: begin
        if (xfer) begin
          if (fullCount == 16'd0)               nextState = DONE;
          else if ({1'b0, fullCount} > CAPACITY) nextState = ERR;
          else                                  nextState = LOAD;
        end
      end
      LOAD:    if (xfer && byteCnt == 2'd3) nextState = WRITE;
      WRITE:   nextState = (remaining == 16'd1) ? DONE : LOAD;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    imem_we    = 1'b0;
    cpu_rst    = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    imem_addr  = wordAddr;
    imem_wdata = wordBuf;
    unique case (state)
      LEN_LO, LEN_HI, LOAD: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      WRITE: begin
        busy    = 1'b1;
        imem_we = 1'b1;
      end
      DONE: begin
        cpu_rst = 1'b1;
        done    = 1'b1;
      end
      ERR:     err = 1'b1;
      default: ;
    endcase
  end

  // Datapath: length capture, byte assembly and write addressing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      countLo   <= '0;
      remaining <= '0;
      wordAddr  <= '0;
      byteCnt   <= '0;
      wordBuf   <= '0;
    end else begin
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            wordAddr <= '0;
            byteCnt  <= '0;
          end
        end
        LEN_LO: if (xfer) countLo <= byte_data;
        LEN_HI: if (xfer) remaining <= fullCount;
        LOAD: begin
          if (xfer) begin
            // Shifting in from the top leaves the first byte in bits 7:0 after four transfers.
            wordBuf <= {byte_data, wordBuf[31:8]};
            byteCnt <= byteCnt + 2'd1;
          end
        end
        WRITE: begin
          wordAddr  <= wordAddr + 1'b1;
          remaining <= remaining - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: default-size instance plus a 4-word
// instance for the capacity/error boundary.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;

  logic        byteReady, imemWe, cpuRst, busy, done, err;
  logic [9:0]  imemAddr;
  logic [31:0] imemWdata;

  logic        sByteReady, sImemWe, sCpuRst, sBusy, sDone, sErr;
  logic [1:0]  sImemAddr;
  logic [31:0] sImemWdata;

  int nCompared   = 0;
  int nMismatched = 0;
  int cyc         = 0;
  int lastAccCyc  = 0;

  logic [31:0] wAddr[$], wData[$], sAddr[$], sData[$];
  int          wCyc[$];
  int          doneRiseCyc, cpuRiseCyc;
  logic        donePrev = 1'b0, cpuPrev = 1'b0;
  logic [7:0]  stim[$];

  imem_boot_loader #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byteReady), .imem_we(imemWe), .imem_addr(imemAddr), .imem_wdata(imemWdata),
    .cpu_rst(cpuRst), .busy(busy), .done(done), .err(err)
  );

  imem_boot_loader #(.ADDR_WIDTH(2)) dutSmall (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(sByteReady), .imem_we(sImemWe), .imem_addr(sImemAddr), .imem_wdata(sImemWdata),
    .cpu_rst(sCpuRst), .busy(sBusy), .done(sDone), .err(sErr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write log and rising-edge timestamps, sampled mid-cycle.
  always @(negedge clk) begin
    if (imemWe) begin
      wAddr.push_back(32'(imemAddr));
      wData.push_back(imemWdata);
      wCyc.push_back(cyc);
    end
    if (sImemWe) begin
      sAddr.push_back(32'(sImemAddr));
      sData.push_back(sImemWdata);
    end
    if (done && !donePrev) doneRiseCyc = cyc;
    if (cpuRst && !cpuPrev) cpuRiseCyc = cyc;
    donePrev = done;
    cpuPrev  = cpuRst;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic clearLog();
    wAddr.delete(); wData.delete(); wCyc.delete();
    sAddr.delete(); sData.delete();
    doneRiseCyc = -1;
    cpuRiseCyc  = -1;
  endtask

  task automatic loadStim(input logic [79:0] packedBytes, input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(packedBytes[8*(n-1-i) +: 8]);
  endtask

  // Presents stim bytes; optionally toggles byte_valid every cycle.
  task automatic sendBytes(input bit toggle, input bit useSmall);
    int idx = 0;
    int budget = 0;
    bit ph = 1'b1;
    while (idx < stim.size() && budget < 400) begin
      @(negedge clk);
      byte_valid = toggle ? ph : 1'b1;
      ph = !ph;
      byte_data = stim[idx];
      if (byte_valid && (useSmall ? sByteReady : byteReady)) begin
        idx++;
        lastAccCyc = cyc;
      end
      budget++;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    check("stream_consumed", 32'(idx), 32'(stim.size()));
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input bit useSmall);
    int budget = 0;
    while (!(useSmall ? sDone : done) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("done_reached", 32'(useSmall ? sDone : done), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_byte_ready"}, 32'(byteReady), 32'd0);
    check({tag, "_imem_we"},    32'(imemWe),    32'd0);
    check({tag, "_imem_addr"},  32'(imemAddr),  32'd0);
    check({tag, "_imem_wdata"}, imemWdata,      32'd0);
    check({tag, "_cpu_rst"},    32'(cpuRst),    32'd0);
    check({tag, "_busy"},       32'(busy),      32'd0);
    check({tag, "_done"},       32'(done),      32'd0);
    check({tag, "_err"},        32'(err),       32'd0);
  endtask

  task automatic checkTwoWords(input string tag);
    check({tag, "_nwrites"}, 32'(wAddr.size()), 32'd2);
    check({tag, "_addr0"},   pick(wAddr, 0),    32'd0);
    check({tag, "_data0"},   pick(wData, 0),    32'h0000_0013);
    check({tag, "_addr1"},   pick(wAddr, 1),    32'd1);
    check({tag, "_data1"},   pick(wData, 1),    32'h0010_0093);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] expSmall [4];
    expSmall[0] = 32'h0302_0100;
    expSmall[1] = 32'h1312_1110;
    expSmall[2] = 32'h2322_2120;
    expSmall[3] = 32'h3332_3130;

    rst = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    clearLog();
    repeat (2) @(negedge clk);
    checkResetOutputs("por");
    check("por_small_cpu_rst", 32'(sCpuRst), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_cpu_rst_held", 32'(cpuRst), 32'd0);

    // Two-word image, valid held high.
    clearLog();
    pulseStart();
    check("start_byte_ready", 32'(byteReady), 32'd1);
    check("start_busy",       32'(busy),      32'd1);
    loadStim(80'h02_00_13_00_00_00_93_00_10_00, 10);
    sendBytes(1'b0, 1'b0);
    waitDone(1'b0);
    checkTwoWords("t1");
    check("t1_write_gap",  32'(pick(wCyc, 1) - pick(wCyc, 0)), 32'd5);
    check("t1_done_lat",   32'(doneRiseCyc - int'(pick(wCyc, 1))), 32'd1);
    check("t1_cpurst_lat", 32'(cpuRiseCyc - int'(pick(wCyc, 1))), 32'd1);
    check("t1_cpu_rst",    32'(cpuRst), 32'd1);

    // Restart from DONE; valid toggling.
    clearLog();
    pulseStart();
    check("restart_cpu_rst_low", 32'(cpuRst), 32'd0);
    check("restart_done_clear",  32'(done),   32'd0);
    sendBytes(1'b1, 1'b0);
    waitDone(1'b0);
    checkTwoWords("t2");

    // Zero-length image.
    clearLog();
    pulseStart();
    loadStim(80'h00_00, 2);
    sendBytes(1'b0, 1'b0);
    waitDone(1'b0);
    check("t3_nwrites",  32'(wAddr.size()), 32'd0);
    check("t3_done_lat", 32'(doneRiseCyc - lastAccCyc), 32'd1);

    // Reset after six payload bytes of a two-word load.
    clearLog();
    pulseStart();
    loadStim(80'h02_00_13_00_00_00_93_00, 8);
    sendBytes(1'b0, 1'b0);
    @(negedge clk);
    check("t4_nwrites_pre", 32'(wAddr.size()), 32'd1);
    check("t4_addr0_pre",   pick(wAddr, 0),    32'd0);
    check("t4_busy_pre",    32'(busy),         32'd1);
    rst = 1'b0;
    #1;
    checkResetOutputs("abort");
    @(negedge clk);
    rst = 1'b1;
    clearLog();
    pulseStart();
    loadStim(80'h02_00_13_00_00_00_93_00_10_00, 10);
    sendBytes(1'b0, 1'b0);
    waitDone(1'b0);
    checkTwoWords("t4");

    // start pulsed mid-load is ignored.
    clearLog();
    pulseStart();
    loadStim(80'h02_00_13_00_00_00_93, 7);
    sendBytes(1'b0, 1'b0);
    pulseStart();
    check("t5_still_busy",  32'(busy),      32'd1);
    check("t5_still_ready", 32'(byteReady), 32'd1);
    loadStim(80'h00_10_00, 3);
    sendBytes(1'b0, 1'b0);
    waitDone(1'b0);
    checkTwoWords("t5");

    // Small memory: oversize count errors, exact capacity loads.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    clearLog();
    pulseStart();
    loadStim(80'h05_00, 2);
    sendBytes(1'b0, 1'b1);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    check("t6_err",        32'(sErr),        32'd1);
    check("t6_cpu_rst",    32'(sCpuRst),     32'd0);
    check("t6_byte_ready", 32'(sByteReady),  32'd0);
    check("t6_nwrites",    32'(sAddr.size()), 32'd0);
    pulseStart();
    check("t6_err_clear",    32'(sErr),       32'd0);
    check("t6_ready_again",  32'(sByteReady), 32'd1);
    loadStim(80'h04_00, 2);
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 4; k++) stim.push_back(8'(16 * w + k));
    sendBytes(1'b0, 1'b1);
    waitDone(1'b1);
    check("t6_full_nwrites", 32'(sAddr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t6_addr%0d", i), pick(sAddr, i), 32'(i));
      check($sformatf("t6_data%0d", i), pick(sData, i), expSmall[i]);
    end
    check("t6_done_cpu_rst", 32'(sCpuRst), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
